// File: rtl/imem_rsp_pkg.sv
// Shared widths, state encodings and default base address for the
// instruction-memory responder.
package imem_rsp_pkg;

  localparam int CPU_WIDTH       = 64;
  localparam int INST_WIDTH      = 32;
  localparam int IMEM_DEPTH_LOG2 = 12;

  localparam logic [CPU_WIDTH-1:0] IMEM_BASE_ADDR = 64'h8000_0000;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_rsp_if.sv
// Fetch request/response channels plus the program-load side port.
// The fetch logic is the master, the memory responder is the slave.
interface imem_rsp_if
  import imem_rsp_pkg::*;
#(
  parameter int ADDR_WIDTH = CPU_WIDTH,
  parameter int DATA_WIDTH = INST_WIDTH,
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_rsp_ram.sv
// Program RAM: one synchronous write port, one synchronous read port with a
// registered output. A read and write to the same word on one edge returns
// the contents from before the write.
module imem_ram
  import imem_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = INST_WIDTH,
  parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_p0,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Program load write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // ---- stage p0: registered read data (read-first against the write) ----
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p0 <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_rsp.sv
// Instruction-memory responder: accepts one fetch at a time, range-checks
// the byte address, reads the program RAM after a fixed latency and holds
// the response until the requester takes it.
module imem_rsp
  import imem_rsp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = CPU_WIDTH,
  parameter int                    DATA_WIDTH = INST_WIDTH,
  parameter int                    DEPTH_LOG2 = IMEM_DEPTH_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(IMEM_BASE_ADDR),
  parameter int                    LATENCY    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_rsp_if.slave     bus
);

  localparam int                    CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(4) << DEPTH_LOG2;

  imem_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;

  logic [ADDR_WIDTH-1:0] off;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  accept;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rdata_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rsp_data_p1;
  logic                  rsp_err_p1;

  // The offset is formed at full address width so that wrap-around below
  // the base is caught by the explicit compare before any truncation.
  assign off     = bus.req_addr - BASE_ADDR;
  assign acc_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                   (off >= SPAN);
  assign acc_idx = off[DEPTH_LOG2+1:2];

  // run_q keeps req_ready low through reset and until the first clock after
  // release, so req_ready depends only on registers.
  assign bus.req_ready = run_q && (state_q == IMEM_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state, latency counter and RAM read issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_addr = idx_q;
    case (state_q)
      IMEM_IDLE: begin
        if (accept) begin
          cnt_d = CNT_LOAD;
          if (LATENCY > 1) begin
            state_d = IMEM_WAIT;
          end else begin
            // Single-cycle latency: read straight from the incoming address.
            state_d = IMEM_RESP;
            rd_en   = !acc_err;
            rd_addr = acc_idx;
          end
        end
      end
      IMEM_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IMEM_RESP;
          rd_en   = !err_q;
        end
      end
      IMEM_RESP: begin
        if (vld_p1 && bus.rsp_ready) state_d = IMEM_IDLE;
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // State register, latency counter and post-reset run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      if (accept) err_q <= acc_err;
    end
  end

  // Word index captured at acceptance; later address changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) idx_q <= acc_idx;
  end

  imem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk        (clk),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data_p0 (ram_rdata_p0),
    .wr_en      (bus.ld_en),
    .wr_addr    (bus.ld_addr),
    .wr_data    (bus.ld_data)
  );

  // ---- stage p1: response register, loaded once per request, held on stall ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else if (state_q == IMEM_RESP && !vld_p1) begin
      vld_p1      <= 1'b1;
      rsp_err_p1  <= err_q;
      rsp_data_p1 <= err_q ? '0 : ram_rdata_p0;
    end else if (vld_p1 && bus.rsp_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_err   = rsp_err_p1;

endmodule
